uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits downstream of uart_rx. It consumes the received byte stream (dout, rx_done_tick) and hunts for a sync byte. It then assembles a length-prefixed, checksummed frame into an internal payload buffer and holds the completed frame for a host until the host acknowledges it. It uses the shared baud-rate s_tick for an inter-byte timeout that resynchronises the parser after a broken frame.

---
 rtl/uart_rx_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame parser downstream of uart_rx. It hunts for the SYNC byte, then takes
//   a length byte, LEN payload bytes and a checksum byte. A frame is valid when
//   (LEN + sum(payload) + CHK) mod 256 == 0. A valid frame is held for the host
//   until frame_ack. An inter-byte timeout, counted in s_tick pulses,
//   resynchronises the parser after a broken frame.
//
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   s_tick           16x baud tick, used as the timeout time base
//   rx_data          received byte from uart_rx
//   rx_done_tick     one-cycle strobe: rx_data is valid
//   frame_ready      a checksum-valid frame is held
//   frame_len        payload length of the last accepted frame
//   rd_addr          payload read index
//   rd_data          payload byte at rd_addr, one cycle of latency
//   frame_ack        host releases the held frame
//   busy             parser is inside a frame (LEN, PAYLOAD or CHK)
//   err_chk          pulse: checksum mismatch
//   err_len          pulse: length byte is 0 or above MAX_LEN
//   err_timeout      pulse: inter-byte timeout inside a frame
//   err_overrun      pulse: byte dropped while a frame is held
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SYNC          = 8'hA5,
  parameter int unsigned TIMEOUT_TICKS = 640,
  localparam int unsigned LW           = $clog2(MAX_LEN + 1),
  localparam int unsigned AW           = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s_tick,
  input  logic [7:0]    rx_data,
  input  logic          rx_done_tick,
  output logic          frame_ready,
  output logic [LW-1:0] frame_len,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic          busy,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int unsigned TW      = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [7:0]  MaxLen8 = 8'(MAX_LEN);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {StHunt, StLen, StPayload, StChk, StHold} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [7:0]    acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem_q [MAX_LEN];
  logic          wr_en;
  logic          in_frame;
  logic [7:0]    chk_sum;
  logic          len_ok;
  logic          last_byte;

  assign in_frame  = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  assign chk_sum   = acc_q + rx_data;
  assign len_ok    = (rx_data != 8'd0) && (rx_data <= MaxLen8);
  assign last_byte = (LW'(idx_q) == len_q - LW'(1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    tmo_d         = tmo_q;
    frame_len_d   = frame_len_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;

    if (in_frame && s_tick) begin
      tmo_d = tmo_q + TW'(1);
    end

    unique case (state_q)
      StHunt: begin
        if (rx_done_tick && (rx_data == SYNC)) begin
          tmo_d   = '0;
          state_d = StLen;
        end
      end
      StLen: begin
        if (rx_done_tick) begin
          tmo_d = '0;
          if (len_ok) begin
            len_d   = LW'(rx_data);
            acc_d   = rx_data;
            idx_d   = '0;
            state_d = StPayload;
          end else begin
            err_len_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StPayload: begin
        if (rx_done_tick) begin
          tmo_d = '0;
          wr_en = 1'b1;
          acc_d = chk_sum;
          idx_d = idx_q + AW'(1);
          if (last_byte) begin
            state_d = StChk;
          end
        end
      end
      StChk: begin
        if (rx_done_tick) begin
          tmo_d = '0;
          if (chk_sum == 8'd0) begin
            frame_len_d = len_q;
            state_d     = StHold;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StHold: begin
        // Buffer is frozen; any byte arriving now is lost, even on the ack cycle.
        if (rx_done_tick) begin
          err_overrun_d = 1'b1;
        end
        if (frame_ack) begin
          state_d = StHunt;
        end
      end
      default: begin
        state_d = StHunt;
      end
    endcase

    // A byte arriving on the terminal tick wins over the timeout.
    if (in_frame && s_tick && !rx_done_tick && (tmo_q == TmoLast)) begin
      err_timeout_d = 1'b1;
      tmo_d         = '0;
      state_d       = StHunt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StHunt;
      len_q         <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      tmo_q         <= '0;
      frame_len_q   <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      tmo_q         <= tmo_d;
      frame_len_q   <= frame_len_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      rd_data_q     <= mem_q[rd_addr];
    end
  end

  // Payload storage needs no reset; contents are only meaningful below frame_len.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q] <= rx_data;
    end
  end

  assign frame_ready = (state_q == StHold);
  assign frame_len   = frame_len_q;
  assign rd_data     = rd_data_q;
  assign busy        = in_frame;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = $clog2(MAX_LEN);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_tick = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done_tick = 1'b0;
  logic          frame_ready;
  logic [LW-1:0] frame_len;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_ack = 1'b0;
  logic          busy;
  logic          err_chk, err_len, err_timeout, err_overrun;

  int checks = 0;
  int errors = 0;
  int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;

  uart_rx_frame_ctrl #(
    .MAX_LEN      (MAX_LEN),
    .SYNC         (8'hA5),
    .TIMEOUT_TICKS(640)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_tick      (s_tick),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .frame_ready (frame_ready),
    .frame_len   (frame_len),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_ack   (frame_ack),
    .busy        (busy),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_len) n_len++;
    if (err_timeout) n_tmo++;
    if (err_overrun) n_ovr++;
    if ((int'(err_chk) + int'(err_len) + int'(err_timeout) + int'(err_overrun)) > 1) n_multi++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    #2;
  endtask

  task automatic read_addr(input logic [AW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    #2;
    d = rd_data;
  endtask

  task automatic ack_frame();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    #2;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({frame_ready, busy, err_chk, err_len, err_timeout, err_overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {frame_ready, busy, err_chk, err_len, err_timeout, err_overrun});
    end
    checks++;
    if (frame_len !== '0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_len_data: got len=%0d data=%h want 0/00", frame_len, rd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_valid_frame();
    logic [7:0] d;
    int ovr0, chk0, len0, tmo0;
    ovr0 = n_ovr; chk0 = n_chk; len0 = n_len; tmo0 = n_tmo;
    send_byte(8'hA5);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL valid_busy_after_sync: got %b want 1", busy);
    end
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    checks++;
    if (frame_ready !== 1'b1 || frame_len !== 5'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_hold: got rdy=%b len=%0d busy=%b want 1/3/0", frame_ready, frame_len,
               busy);
    end
    read_addr(4'd0, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL valid_rd0: got %h want 11", d); end
    read_addr(4'd1, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL valid_rd1: got %h want 22", d); end
    read_addr(4'd2, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL valid_rd2: got %h want 33", d); end
    checks++;
    if ((n_ovr - ovr0) + (n_chk - chk0) + (n_len - len0) + (n_tmo - tmo0) != 0) begin
      errors++; $display("FAIL valid_no_err: got %0d pulses want 0",
                         (n_ovr - ovr0) + (n_chk - chk0) + (n_len - len0) + (n_tmo - tmo0));
    end
    ack_frame();
    checks++;
    if (frame_ready !== 1'b0 || frame_len !== 5'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL valid_ack: got rdy=%b len=%0d busy=%b want 0/3/0", frame_ready, frame_len,
               busy);
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] d;
    int chk0;
    chk0 = n_chk;
    send_byte(8'h00); send_byte(8'hFF);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL chk_garbage_busy: got %b want 0", busy); end
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h98);
    checks++;
    if (err_chk !== 1'b1) begin errors++; $display("FAIL chk_pulse: got %b want 1", err_chk); end
    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (n_chk - chk0 != 1 || frame_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chk_once: got pulses=%0d rdy=%b busy=%b want 1/0/0", n_chk - chk0,
               frame_ready, busy);
    end
    // 02 + 44 + 55 = 9B, so CHK = 65
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44); send_byte(8'h55); send_byte(8'h65);
    checks++;
    if (frame_ready !== 1'b1 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL chk_recover: got rdy=%b len=%0d want 1/2", frame_ready, frame_len);
    end
    read_addr(4'd1, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL chk_recover_rd1: got %h want 55", d); end
    ack_frame();
  endtask

  task automatic test_bad_len();
    int len0;
    len0 = n_len;
    send_byte(8'hA5); send_byte(8'h00);
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len_zero: got err=%b busy=%b want 1/0", err_len, busy);
    end
    send_byte(8'hA5); send_byte(8'h11);
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL len_17: got err=%b busy=%b want 1/0", err_len, busy);
    end
    // A second SYNC in LEN is a length (0xA5 > MAX_LEN), not a resync.
    send_byte(8'hA5); send_byte(8'hA5);
    checks++;
    if (err_len !== 1'b1 || busy !== 1'b0 || n_len - len0 != 3) begin
      errors++;
      $display("FAIL len_sync_as_len: got err=%b busy=%b pulses=%0d want 1/0/3", err_len, busy,
               n_len - len0);
    end
  endtask

  task automatic test_max_len();
    logic [7:0] acc;
    logic [7:0] d;
    acc = 8'h10;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 3 + 1));
      acc = acc + 8'(i * 3 + 1);
    end
    send_byte(8'h00 - acc);
    checks++;
    if (frame_ready !== 1'b1 || frame_len !== 5'd16) begin
      errors++;
      $display("FAIL maxlen_hold: got rdy=%b len=%0d want 1/16", frame_ready, frame_len);
    end
    read_addr(4'd15, d);
    checks++;
    if (d !== 8'd46) begin errors++; $display("FAIL maxlen_rd15: got %h want 2e", d); end
    read_addr(4'd0, d);
    checks++;
    if (d !== 8'd1) begin errors++; $display("FAIL maxlen_rd0: got %h want 01", d); end
    ack_frame();
  endtask

  task automatic test_timeout();
    int tmo0;
    tmo0 = n_tmo;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    @(negedge clk);
    s_tick = 1'b1;
    repeat (639) @(negedge clk);
    #2;
    checks++;
    if (n_tmo - tmo0 != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: got pulses=%0d busy=%b want 0/1", n_tmo - tmo0, busy);
    end
    @(negedge clk);
    s_tick = 1'b0;
    #2;
    checks++;
    if (err_timeout !== 1'b1 || n_tmo - tmo0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_640: got err=%b pulses=%0d busy=%b want 1/1/0", err_timeout,
               n_tmo - tmo0, busy);
    end
    // Second run: byte lands on the 640th tick.
    tmo0 = n_tmo;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    @(negedge clk);
    s_tick = 1'b1;
    repeat (639) @(negedge clk);
    rx_data = 8'h22;
    rx_done_tick = 1'b1;
    @(negedge clk);
    s_tick = 1'b0;
    rx_done_tick = 1'b0;
    #2;
    checks++;
    if (n_tmo - tmo0 != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_byte_wins: got pulses=%0d busy=%b want 0/1", n_tmo - tmo0, busy);
    end
    // 02 + 11 + 22 = 35, so CHK = CB
    send_byte(8'hCB);
    checks++;
    if (frame_ready !== 1'b1 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL tmo_frame_done: got rdy=%b len=%0d want 1/2", frame_ready, frame_len);
    end
  endtask

  // Entered with the frame 11 22 (len 2) held.
  task automatic test_overrun();
    logic [7:0] d;
    int ovr0, tmo0;
    ovr0 = n_ovr;
    tmo0 = n_tmo;
    send_byte(8'h5A);
    checks++;
    if (err_overrun !== 1'b1 || frame_ready !== 1'b1 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL ovr_pulse: got err=%b rdy=%b len=%0d want 1/1/2", err_overrun, frame_ready,
               frame_len);
    end
    read_addr(4'd0, d);
    checks++;
    if (d !== 8'h11) begin errors++; $display("FAIL ovr_rd0: got %h want 11", d); end
    // The timeout counter sleeps in HOLD.
    @(negedge clk);
    s_tick = 1'b1;
    repeat (700) @(negedge clk);
    s_tick = 1'b0;
    #2;
    checks++;
    if (n_tmo - tmo0 != 0 || frame_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovr_hold_no_tmo: got pulses=%0d rdy=%b want 0/1", n_tmo - tmo0, frame_ready);
    end
    @(negedge clk);
    frame_ack = 1'b1;
    rx_data = 8'h5A;
    rx_done_tick = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    rx_done_tick = 1'b0;
    #2;
    checks++;
    if (n_ovr - ovr0 != 2 || frame_ready !== 1'b0 || frame_len !== 5'd2) begin
      errors++;
      $display("FAIL ovr_ack_same_cycle: got pulses=%0d rdy=%b len=%0d want 2/0/2", n_ovr - ovr0,
               frame_ready, frame_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({frame_ready, busy, err_chk, err_len, err_timeout, err_overrun} !== 6'b0 ||
        frame_len !== '0 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid: got flags=%b len=%0d data=%h want 000000/0/00",
               {frame_ready, busy, err_chk, err_len, err_timeout, err_overrun}, frame_len, rd_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    // 01 + 7F = 80, so CHK = 80
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    checks++;
    if (frame_ready !== 1'b1 || frame_len !== 5'd1) begin
      errors++;
      $display("FAIL rst_recover: got rdy=%b len=%0d want 1/1", frame_ready, frame_len);
    end
    read_addr(4'd0, d);
    checks++;
    if (d !== 8'h7F) begin errors++; $display("FAIL rst_recover_rd0: got %h want 7f", d); end
    ack_frame();
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_chk();
    test_bad_len();
    test_max_len();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL one_err_per_cycle: got %0d cycles want 0", n_multi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
